// File: rtl/multiplier_arbiter.sv
// Round-robin arbiter sharing one sequential multiplier between two level-request ports.
// Latency: St one cycle after grant; done pulse one cycle after Done, or TIMEOUT+1 cycles after St on abort.
// Backpressure: requests are held until granted; no grant while the multiplier reports Idle=0.
module multiplier_arbiter #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic               Clk,
    input  logic               reset,
    input  logic               req0,
    input  logic [WIDTH-1:0]   mcand0,
    input  logic [WIDTH-1:0]   mplier0,
    output logic               done0,
    input  logic               req1,
    input  logic [WIDTH-1:0]   mcand1,
    input  logic [WIDTH-1:0]   mplier1,
    output logic               done1,
    output logic [2*WIDTH-1:0] result,
    output logic               err,
    output logic               busy,
    output logic               owner,
    output logic               St,
    output logic [WIDTH-1:0]   Multiplicando,
    output logic [WIDTH-1:0]   Multiplicador,
    input  logic               Idle,
    input  logic               Done,
    input  logic [2*WIDTH-1:0] Produto
);
    localparam int            CW   = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_RESP} state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic          last_owner;
    logic          pick1;

    // On a tie the port that was not served last wins, so neither port can starve.
    assign pick1 = req1 & (~req0 | ~last_owner);

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            count         <= '0;
            last_owner    <= 1'b1;
            owner         <= 1'b0;
            St            <= 1'b0;
            done0         <= 1'b0;
            done1         <= 1'b0;
            busy          <= 1'b0;
            err           <= 1'b0;
            result        <= '0;
            Multiplicando <= '0;
            Multiplicador <= '0;
        end else begin
            St    <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            case (state)
                S_IDLE: begin
                    if ((req0 | req1) && Idle) begin
                        owner         <= pick1;
                        Multiplicando <= pick1 ? mcand1  : mcand0;
                        Multiplicador <= pick1 ? mplier1 : mplier0;
                        St            <= 1'b1;
                        busy          <= 1'b1;
                        state         <= S_START;
                    end
                end
                S_START: begin
                    count <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // Done takes priority over an expiring watchdog in the same cycle.
                    if (Done) begin
                        result <= Produto;
                        err    <= 1'b0;
                        done0  <= ~owner;
                        done1  <= owner;
                        state  <= S_RESP;
                    end else if (count == LAST) begin
                        result <= '0;
                        err    <= 1'b1;
                        done0  <= ~owner;
                        done1  <= owner;
                        state  <= S_RESP;
                    end else begin
                        count <= count + CW'(1);
                    end
                end
                S_RESP: begin
                    last_owner <= owner;
                    busy       <= 1'b0;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_multiplier_arbiter.sv
// Randomized scoreboard bench: round-robin order model, behavioural multiplier, watchdog and reset checks.
`timescale 1ns/1ps
module tb_multiplier_arbiter;
    localparam int W  = 16;
    localparam int TO = 8;

    logic           Clk = 1'b0;
    logic           reset;
    logic           req0, req1;
    logic [W-1:0]   mcand0, mplier0, mcand1, mplier1;
    logic           done0, done1, err, busy, owner, St;
    logic [2*W-1:0] result;
    logic [W-1:0]   Multiplicando, Multiplicador;
    logic           Idle, Done;
    logic [2*W-1:0] Produto;

    always #5 Clk = ~Clk;

    multiplier_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .Clk(Clk), .reset(reset),
        .req0(req0), .mcand0(mcand0), .mplier0(mplier0), .done0(done0),
        .req1(req1), .mcand1(mcand1), .mplier1(mplier1), .done1(done1),
        .result(result), .err(err), .busy(busy), .owner(owner), .St(St),
        .Multiplicando(Multiplicando), .Multiplicador(Multiplicador),
        .Idle(Idle), .Done(Done), .Produto(Produto)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge Clk) cyc++;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Behavioural multiplier: latency chosen per operation (0 = never finishes).
    int          lat_mode = 0;
    bit          idle_force0 = 1'b0;
    int          pend = 0;
    int          op_lat = 0;
    logic [31:0] prod_l;
    assign Idle = ~idle_force0;

    always @(posedge Clk or negedge reset) begin
        if (!reset) begin
            pend = 0;
            Done    <= 1'b0;
            Produto <= '0;
        end else begin
            Done    <= 1'b0;
            Produto <= $urandom;
            if (St) begin
                op_lat = (lat_mode == 0) ? $urandom_range(1, TO + 2) : (lat_mode < 0 ? 0 : lat_mode);
                prod_l = 32'(Multiplicando) * 32'(Multiplicador);
                pend   = op_lat;
            end
            if (pend == 1) begin
                Done    <= 1'b1;
                Produto <= prod_l;
            end
            if (pend > 0) pend--;
        end
    end

    typedef struct {
        bit          port;
        logic [31:0] prod;
    } exp_t;
    exp_t sb[$];

    int st_cnt = 0;
    int st_cyc = 0;

    // Monitor: pops the scoreboard whenever a done pulse appears.
    always @(negedge Clk) begin
        if (reset) begin
            if (St) begin
                st_cnt++;
                st_cyc = cyc;
            end
            if (done0 && done1) begin
                checks++; errors++;
                $display("FAIL both_done: done0=1 done1=1, expected at most one");
            end else if (done0 || done1) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: done0=%0b done1=%0b with no outstanding request", done0, done1);
                end else begin
                    exp_t e;
                    bit   timed_out;
                    e = sb.pop_front();
                    timed_out = (op_lat == 0) || (op_lat > TO);
                    check("done_port", 64'(done1), 64'(e.port));
                    check("owner", 64'(owner), 64'(e.port));
                    check("err", 64'(err), 64'(timed_out));
                    check("result", 64'(result), timed_out ? 64'd0 : 64'(e.prod));
                    check("latency", 64'(cyc - st_cyc), timed_out ? 64'(TO + 1) : 64'(op_lat + 1));
                    check("st_pulses", 64'(st_cnt), 64'd1);
                    st_cnt = 0;
                end
            end
        end
    end

    logic [W-1:0] a0[$], b0[$], a1[$], b1[$];
    bit last_served = 1'b1;

    task automatic add_op(input bit p, input logic [W-1:0] a, input logic [W-1:0] b);
        if (!p) begin a0.push_back(a); b0.push_back(b); end
        else    begin a1.push_back(a); b1.push_back(b); end
    endtask

    task automatic drive(input bit p, input int n);
        for (int i = 0; i < n; i++) begin
            int t = 0;
            if (!p) begin mcand0 = a0.pop_front(); mplier0 = b0.pop_front(); req0 = 1'b1; end
            else    begin mcand1 = a1.pop_front(); mplier1 = b1.pop_front(); req1 = 1'b1; end
            do begin
                @(negedge Clk);
                t++;
            end while (!(p ? done1 : done0) && t < 400);
            if (t >= 400) begin
                checks++; errors++;
                $display("FAIL wait_done: port %0d saw no done within 400 cycles", p);
                break;
            end
            @(posedge Clk);
            #1;
        end
        if (!p) req0 = 1'b0; else req1 = 1'b0;
    endtask

    // Expected service order: alternate while both have work, otherwise whoever has work.
    task automatic run_batch();
        int n0 = a0.size();
        int n1 = a1.size();
        int i0 = 0;
        int i1 = 0;
        while (i0 < n0 || i1 < n1) begin
            bit pick;
            if (i0 < n0 && i1 < n1) pick = ~last_served;
            else                    pick = (i0 < n0) ? 1'b0 : 1'b1;
            if (!pick) begin sb.push_back('{1'b0, 32'(a0[i0]) * 32'(b0[i0])}); i0++; end
            else       begin sb.push_back('{1'b1, 32'(a1[i1]) * 32'(b1[i1])}); i1++; end
            last_served = pick;
        end
        fork
            drive(1'b0, n0);
            drive(1'b1, n1);
        join
        repeat (2) @(negedge Clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_St"}, 64'(St), 64'd0);
        check({tag, "_done"}, 64'({done0, done1}), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_err"}, 64'(err), 64'd0);
        check({tag, "_owner"}, 64'(owner), 64'd0);
        check({tag, "_result"}, 64'(result), 64'd0);
        check({tag, "_operands"}, 64'({Multiplicando, Multiplicador}), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        mcand0 = '0; mplier0 = '0; mcand1 = '0; mplier1 = '0;
        #2 reset = 1'b0;
        #10 check_reset_outputs("rst");
        @(negedge Clk) reset = 1'b1;
        @(posedge Clk); #1;

        lat_mode = 4;
        add_op(1'b0, 16'd2000, 16'd2000);
        run_batch();
        check("t1_result", 64'(result), 64'h003D0900);

        add_op(1'b1, 16'd15, 16'd15);
        run_batch();
        check("t2_result", 64'(result), 64'd225);
        check("t2_owner", 64'(owner), 64'd1);

        add_op(1'b0, 16'hFFFF, 16'hFFFF);
        run_batch();
        check("t3_result", 64'(result), 64'hFFFE0001);

        lat_mode = 0;
        for (int i = 0; i < 4; i++) begin
            add_op(1'b0, 16'($urandom), 16'($urandom));
            add_op(1'b1, 16'($urandom), 16'($urandom));
        end
        run_batch();

        for (int k = 0; k < 6; k++) begin
            int n0 = $urandom_range(0, 3);
            int n1 = $urandom_range(0, 3);
            for (int i = 0; i < n0; i++) add_op(1'b0, 16'($urandom), 16'($urandom));
            for (int i = 0; i < n1; i++) add_op(1'b1, 16'($urandom), 16'($urandom));
            run_batch();
        end

        lat_mode = TO;
        add_op(1'b0, 16'd300, 16'd7);
        add_op(1'b1, 16'd9, 16'd11);
        run_batch();
        lat_mode = TO + 1;
        add_op(1'b0, 16'd5, 16'd5);
        run_batch();

        lat_mode = -1;
        add_op(1'b1, 16'd123, 16'd45);
        run_batch();
        check("t5_err", 64'(err), 64'd1);
        check("t5_result", 64'(result), 64'd0);
        lat_mode = 3;
        add_op(1'b0, 16'd40, 16'd50);
        run_batch();
        check("t5_recover", 64'(result), 64'd2000);

        lat_mode = -1;
        add_op(1'b1, 16'd7, 16'd7);
        run_batch();
        mcand1 = 16'd99; mplier1 = 16'd3; req1 = 1'b1;
        begin
            int t = 0;
            while (!busy && t < 50) begin @(negedge Clk); t++; end
            check("t6_reached_busy", 64'(busy), 64'd1);
        end
        repeat (3) @(negedge Clk);
        #2 reset = 1'b0;
        #1 check_reset_outputs("t6");
        idle_force0 = 1'b1;
        last_served = 1'b1;
        st_cnt = 0;
        @(negedge Clk) #2 reset = 1'b1;
        repeat (20) @(negedge Clk);
        check("t6_no_st", 64'(st_cnt), 64'd0);
        check("t6_idle_busy", 64'(busy), 64'd0);
        req1 = 1'b0;
        idle_force0 = 1'b0;
        lat_mode = 0;
        @(posedge Clk); #1;
        add_op(1'b0, 16'($urandom), 16'($urandom));
        add_op(1'b1, 16'($urandom), 16'($urandom));
        add_op(1'b1, 16'($urandom), 16'($urandom));
        run_batch();

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
